// File: rtl/memory_request_pipe_pkg.sv
// Shared payload widths and FIFO entry layout for the core-side memory pipe.
// The arbiter imports the same package so both ends agree on the entry format.
package memory_request_pipe_pkg;

  localparam int unsigned MMU_MODE_W = 2;
  localparam int unsigned ORDER_W    = 2;
  localparam int unsigned PDT_W      = 32;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned RDATA_W    = 64;
  localparam int unsigned FLAGS_W    = 28;

  // One queued request as held in the request FIFO.
  typedef struct packed {
    logic                  storeAck;
    logic [MMU_MODE_W-1:0] mmuMode;
    logic [PDT_W-1:0]      pdt;
    logic [ORDER_W-1:0]    order;
    logic                  rw;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     data;
  } reqEntry_t;

  localparam int unsigned REQ_ENTRY_W = $bits(reqEntry_t);

  // Registered return toward the arbiter: either a read return or a store ack.
  typedef struct packed {
    logic               valid;
    logic               storeAck;
    logic               pageFault;
    logic               queueFlush;
    logic [RDATA_W-1:0] data;
    logic [FLAGS_W-1:0] flags;
  } retEntry_t;

  function automatic reqEntry_t make_req_entry(
    input logic                  storeAck,
    input logic [MMU_MODE_W-1:0] mmuMode,
    input logic [PDT_W-1:0]      pdt,
    input logic [ORDER_W-1:0]    order,
    input logic                  rw,
    input logic [ADDR_W-1:0]     addr,
    input logic [DATA_W-1:0]     data
  );
    reqEntry_t e;
    e.storeAck = storeAck;
    e.mmuMode  = mmuMode;
    e.pdt      = pdt;
    e.order    = order;
    e.rw       = rw;
    e.addr     = addr;
    e.data     = data;
    return e;
  endfunction

endpackage

// File: rtl/memory_request_pipe_if.sv
// Bus bundle between arbiter (PREV side), this pipe, and the memory/MMU controller (NEXT side).
interface memory_request_pipe_if;
  import memory_request_pipe_pkg::*;

  // Arbiter -> pipe requests and pipe -> arbiter returns
  logic                  iPREV_REQ;
  logic                  oPREV_LOCK;
  logic                  iPREV_DATA_STORE_ACK;
  logic [MMU_MODE_W-1:0] iPREV_MMU_MODE;
  logic [PDT_W-1:0]      iPREV_PDT;
  logic [ORDER_W-1:0]    iPREV_ORDER;
  logic                  iPREV_RW;
  logic [ADDR_W-1:0]     iPREV_ADDR;
  logic [DATA_W-1:0]     iPREV_DATA;
  logic                  oPREV_VALID;
  logic                  iPREV_BUSY;
  logic                  oPREV_STORE_ACK;
  logic                  oPREV_PAGE_FAULT;
  logic                  oPREV_QUEUE_FLUSH;
  logic [RDATA_W-1:0]    oPREV_DATA;
  logic [FLAGS_W-1:0]    oPREV_MMU_FLAGS;

  // Pipe -> memory requests and memory -> pipe read returns
  logic                  oNEXT_REQ;
  logic                  iNEXT_LOCK;
  logic [MMU_MODE_W-1:0] oNEXT_MMU_MODE;
  logic [PDT_W-1:0]      oNEXT_PDT;
  logic [ORDER_W-1:0]    oNEXT_ORDER;
  logic                  oNEXT_RW;
  logic [ADDR_W-1:0]     oNEXT_ADDR;
  logic [DATA_W-1:0]     oNEXT_DATA;
  logic                  iNEXT_VALID;
  logic                  oNEXT_BUSY;
  logic                  iNEXT_PAGE_FAULT;
  logic                  iNEXT_QUEUE_FLUSH;
  logic [RDATA_W-1:0]    iNEXT_DATA;
  logic [FLAGS_W-1:0]    iNEXT_MMU_FLAGS;

  modport prev_slave (
    input  iPREV_REQ, iPREV_DATA_STORE_ACK, iPREV_MMU_MODE, iPREV_PDT, iPREV_ORDER,
           iPREV_RW, iPREV_ADDR, iPREV_DATA, iPREV_BUSY,
    output oPREV_LOCK, oPREV_VALID, oPREV_STORE_ACK, oPREV_PAGE_FAULT, oPREV_QUEUE_FLUSH,
           oPREV_DATA, oPREV_MMU_FLAGS
  );

  modport prev_master (
    output iPREV_REQ, iPREV_DATA_STORE_ACK, iPREV_MMU_MODE, iPREV_PDT, iPREV_ORDER,
           iPREV_RW, iPREV_ADDR, iPREV_DATA, iPREV_BUSY,
    input  oPREV_LOCK, oPREV_VALID, oPREV_STORE_ACK, oPREV_PAGE_FAULT, oPREV_QUEUE_FLUSH,
           oPREV_DATA, oPREV_MMU_FLAGS
  );

  modport next_master (
    output oNEXT_REQ, oNEXT_MMU_MODE, oNEXT_PDT, oNEXT_ORDER, oNEXT_RW, oNEXT_ADDR,
           oNEXT_DATA, oNEXT_BUSY,
    input  iNEXT_LOCK, iNEXT_VALID, iNEXT_PAGE_FAULT, iNEXT_QUEUE_FLUSH, iNEXT_DATA,
           iNEXT_MMU_FLAGS
  );

  modport next_slave (
    input  oNEXT_REQ, oNEXT_MMU_MODE, oNEXT_PDT, oNEXT_ORDER, oNEXT_RW, oNEXT_ADDR,
           oNEXT_DATA, oNEXT_BUSY,
    output iNEXT_LOCK, iNEXT_VALID, iNEXT_PAGE_FAULT, iNEXT_QUEUE_FLUSH, iNEXT_DATA,
           iNEXT_MMU_FLAGS
  );

endinterface

// File: rtl/memory_request_fifo.sv
// Synchronous request FIFO with full/empty/count; head is read combinationally.
// Push and pop may coincide at any occupancy, including full.
module memory_request_fifo #(
  parameter  int unsigned P_DEPTH = 4,
  parameter  int unsigned P_WIDTH = 8,
  localparam int unsigned CNT_W   = $clog2(P_DEPTH) + 1
) (
  input  logic               iCLOCK,
  input  logic               inRESET,
  input  logic               iPUSH,
  input  logic               iPOP,
  input  logic [P_WIDTH-1:0] iWDATA,
  output logic [P_WIDTH-1:0] oRDATA,
  output logic               oFULL,
  output logic               oEMPTY,
  output logic [CNT_W-1:0]   oCOUNT
);

  localparam int unsigned PTR_W = $clog2(P_DEPTH);

  logic [P_WIDTH-1:0] mem [P_DEPTH];
  logic [PTR_W-1:0]   wrPtrQ;
  logic [PTR_W-1:0]   rdPtrQ;
  logic [CNT_W-1:0]   countQ;
  logic [CNT_W-1:0]   countD;
  logic               pushEn;
  logic               popEn;

  assign oFULL  = (countQ == CNT_W'(P_DEPTH));
  assign oEMPTY = (countQ == '0);
  assign oCOUNT = countQ;
  assign oRDATA = mem[rdPtrQ];

  // A pop frees the head slot in the same edge, so push into a full FIFO is legal then.
  assign pushEn = iPUSH && (!oFULL || iPOP);
  assign popEn  = iPOP && !oEMPTY;

  always_comb begin
    countD = countQ;
    case ({pushEn, popEn})
      2'b10:   countD = countQ + CNT_W'(1);
      2'b01:   countD = countQ - CNT_W'(1);
      default: countD = countQ;
    endcase
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      wrPtrQ <= '0;
      rdPtrQ <= '0;
      countQ <= '0;
      for (int i = 0; i < P_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (pushEn) begin
        mem[wrPtrQ] <= iWDATA;
        wrPtrQ      <= wrPtrQ + PTR_W'(1);
      end
      if (popEn) begin
        rdPtrQ <= rdPtrQ + PTR_W'(1);
      end
      countQ <= countD;
    end
  end

endmodule

// File: rtl/memory_request_pipe.sv
// Buffers arbitrated requests toward memory, acks posted stores locally, and merges
// read returns with those acks into one registered, backpressured return stream.
module memory_request_pipe
  import memory_request_pipe_pkg::*;
#(
  parameter int unsigned P_REQ_DEPTH = 4,
  parameter int unsigned P_ACK_MAX   = 15
) (
  input logic                           iCLOCK,
  input logic                           inRESET,
  memory_request_pipe_if.prev_slave     prevIf,
  memory_request_pipe_if.next_master    nextIf
);

  localparam int unsigned ACK_W = $clog2(P_ACK_MAX + 1);
  localparam int unsigned CNT_W = $clog2(P_REQ_DEPTH) + 1;

  reqEntry_t  fifoWdata;
  reqEntry_t  head;
  logic [REQ_ENTRY_W-1:0] fifoRdata;
  logic       fifoFull;
  logic       fifoEmpty;
  logic [CNT_W-1:0] fifoCount;
  logic       unusedFifoCount;

  logic       transfer;
  logic       issue;
  logic       nextReq;

  logic [ACK_W-1:0] ackCntQ;
  logic [ACK_W-1:0] ackCntD;
  logic       ackFull;
  logic       ackInc;
  logic       ackDec;

  retEntry_t  retQ;
  retEntry_t  retD;
  logic       retLoad;

  // ---------------------------------------------------------------------------
  // Request path
  // ---------------------------------------------------------------------------
  assign fifoWdata = make_req_entry(prevIf.iPREV_DATA_STORE_ACK, prevIf.iPREV_MMU_MODE,
                                    prevIf.iPREV_PDT, prevIf.iPREV_ORDER, prevIf.iPREV_RW,
                                    prevIf.iPREV_ADDR, prevIf.iPREV_DATA);
  assign head      = reqEntry_t'(fifoRdata);

  assign transfer = prevIf.iPREV_REQ && !fifoFull;
  // A store needing an ack waits at the head while the ack counter has no room.
  assign nextReq  = !fifoEmpty && !(head.storeAck && ackFull);
  assign issue    = nextReq && !nextIf.iNEXT_LOCK;

  memory_request_fifo #(
    .P_DEPTH (P_REQ_DEPTH),
    .P_WIDTH (REQ_ENTRY_W)
  ) u_fifo (
    .iCLOCK  (iCLOCK),
    .inRESET (inRESET),
    .iPUSH   (transfer),
    .iPOP    (issue),
    .iWDATA  (fifoWdata),
    .oRDATA  (fifoRdata),
    .oFULL   (fifoFull),
    .oEMPTY  (fifoEmpty),
    .oCOUNT  (fifoCount)
  );

  assign unusedFifoCount = ^fifoCount;

  assign prevIf.oPREV_LOCK    = fifoFull;
  assign nextIf.oNEXT_REQ     = nextReq;
  assign nextIf.oNEXT_MMU_MODE = head.mmuMode;
  assign nextIf.oNEXT_PDT     = head.pdt;
  assign nextIf.oNEXT_ORDER   = head.order;
  assign nextIf.oNEXT_RW      = head.rw;
  assign nextIf.oNEXT_ADDR    = head.addr;
  assign nextIf.oNEXT_DATA    = head.data;

  // ---------------------------------------------------------------------------
  // Pending store-ack counter
  // ---------------------------------------------------------------------------
  assign ackFull = (ackCntQ == ACK_W'(P_ACK_MAX));
  assign ackInc  = issue && head.storeAck;
  // Read returns win the return register, so an ack only drains on a free slot.
  assign ackDec  = retLoad && !nextIf.iNEXT_VALID && (ackCntQ != '0);

  always_comb begin
    ackCntD = ackCntQ;
    case ({ackInc, ackDec})
      2'b10:   ackCntD = ackCntQ + ACK_W'(1);
      2'b01:   ackCntD = ackCntQ - ACK_W'(1);
      default: ackCntD = ackCntQ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Return register
  // ---------------------------------------------------------------------------
  assign retLoad = !retQ.valid || !prevIf.iPREV_BUSY;

  always_comb begin
    retD = retQ;
    if (retLoad) begin
      retD = '0;
      if (nextIf.iNEXT_VALID) begin
        retD.valid      = 1'b1;
        retD.pageFault  = nextIf.iNEXT_PAGE_FAULT;
        retD.queueFlush = nextIf.iNEXT_QUEUE_FLUSH;
        retD.data       = nextIf.iNEXT_DATA;
        retD.flags      = nextIf.iNEXT_MMU_FLAGS;
      end else if (ackCntQ != '0) begin
        retD.valid    = 1'b1;
        retD.storeAck = 1'b1;
      end
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      ackCntQ <= '0;
      retQ    <= '0;
    end else begin
      ackCntQ <= ackCntD;
      retQ    <= retD;
    end
  end

  assign prevIf.oPREV_VALID       = retQ.valid;
  assign prevIf.oPREV_STORE_ACK   = retQ.storeAck;
  assign prevIf.oPREV_PAGE_FAULT  = retQ.pageFault;
  assign prevIf.oPREV_QUEUE_FLUSH = retQ.queueFlush;
  assign prevIf.oPREV_DATA        = retQ.data;
  assign prevIf.oPREV_MMU_FLAGS   = retQ.flags;
  // Memory holds its read return while the upstream refuses ours.
  assign nextIf.oNEXT_BUSY        = retQ.valid && prevIf.iPREV_BUSY;

endmodule

// File: tb/tb_memory_request_pipe.sv
// Directed bench for memory_request_pipe: ordering, posted store acks, return priority,
// backpressure, ack saturation and asynchronous reset.
module tb_memory_request_pipe;

  logic iCLOCK  = 1'b0;
  logic inRESET = 1'b0;
  int   nChecks = 0;
  int   nFail   = 0;

  always #5 iCLOCK = ~iCLOCK;

  memory_request_pipe_if bus ();

  memory_request_pipe #(
    .P_REQ_DEPTH (4),
    .P_ACK_MAX   (15)
  ) dut (
    .iCLOCK  (iCLOCK),
    .inRESET (inRESET),
    .prevIf  (bus),
    .nextIf  (bus)
  );

  task automatic tick();
    @(posedge iCLOCK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.iPREV_REQ            = 1'b0;
    bus.iPREV_DATA_STORE_ACK = 1'b0;
    bus.iPREV_MMU_MODE       = 2'b01;
    bus.iPREV_PDT            = 32'h0000_1000;
    bus.iPREV_ORDER          = 2'b10;
    bus.iPREV_RW             = 1'b0;
    bus.iPREV_ADDR           = '0;
    bus.iPREV_DATA           = '0;
    bus.iPREV_BUSY           = 1'b0;
    bus.iNEXT_LOCK           = 1'b0;
    bus.iNEXT_VALID          = 1'b0;
    bus.iNEXT_PAGE_FAULT     = 1'b0;
    bus.iNEXT_QUEUE_FLUSH    = 1'b0;
    bus.iNEXT_DATA           = '0;
    bus.iNEXT_MMU_FLAGS      = '0;
  endtask

  // Holds a request until it transfers; a lock that never clears counts as a failure.
  task automatic push_req(input logic ack, input logic rw, input logic [31:0] addr,
                          input logic [31:0] data);
    logic locked;
    logic done;
    done = 1'b0;
    bus.iPREV_REQ            = 1'b1;
    bus.iPREV_DATA_STORE_ACK = ack;
    bus.iPREV_RW             = rw;
    bus.iPREV_ADDR           = addr;
    bus.iPREV_DATA           = data;
    for (int i = 0; i < 64 && !done; i++) begin
      locked = bus.oPREV_LOCK;
      tick();
      if (!locked) done = 1'b1;
    end
    if (!done) begin
      nChecks++; nFail++;
      $display("FAIL push_timeout: addr %h never transferred, lock=%b required 0", addr,
               bus.oPREV_LOCK);
    end
    bus.iPREV_REQ = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    inRESET = 1'b0;
    #12;
    nChecks++; if (bus.oPREV_LOCK !== 1'b0) begin nFail++; $display("FAIL rst_lock: got %b required 0", bus.oPREV_LOCK); end
    nChecks++; if (bus.oNEXT_REQ !== 1'b0) begin nFail++; $display("FAIL rst_next_req: got %b required 0", bus.oNEXT_REQ); end
    nChecks++; if (bus.oPREV_VALID !== 1'b0) begin nFail++; $display("FAIL rst_valid: got %b required 0", bus.oPREV_VALID); end
    nChecks++; if (bus.oNEXT_BUSY !== 1'b0) begin nFail++; $display("FAIL rst_busy: got %b required 0", bus.oNEXT_BUSY); end
    nChecks++; if (bus.oNEXT_ADDR !== 32'h0) begin nFail++; $display("FAIL rst_next_addr: got %h required 0", bus.oNEXT_ADDR); end
    nChecks++; if (bus.oPREV_DATA !== 64'h0) begin nFail++; $display("FAIL rst_prev_data: got %h required 0", bus.oPREV_DATA); end
    inRESET = 1'b1;
    tick();
  endtask

  task automatic test_fifo_order();
    bus.iNEXT_LOCK = 1'b1;
    for (int i = 0; i < 4; i++) push_req(1'b0, 1'b0, 32'h100 + 32'(4 * i), 32'(i));
    bus.iPREV_REQ  = 1'b1;
    bus.iPREV_ADDR = 32'h110;
    #1;
    nChecks++; if (bus.oPREV_LOCK !== 1'b1) begin nFail++; $display("FAIL fifo_full_lock: got %b required 1", bus.oPREV_LOCK); end
    nChecks++; if (bus.oNEXT_REQ !== 1'b1) begin nFail++; $display("FAIL fifo_head_req: got %b required 1", bus.oNEXT_REQ); end
    bus.iPREV_REQ  = 1'b0;
    bus.iNEXT_LOCK = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      nChecks++;
      if (bus.oNEXT_REQ !== 1'b1 || bus.oNEXT_ADDR !== 32'h100 + 32'(4 * i) || bus.oNEXT_RW !== 1'b0) begin
        nFail++;
        $display("FAIL fifo_order[%0d]: req=%b addr=%h rw=%b required 1/%h/0", i, bus.oNEXT_REQ,
                 bus.oNEXT_ADDR, bus.oNEXT_RW, 32'h100 + 32'(4 * i));
      end
      tick();
    end
    nChecks++; if (bus.oNEXT_REQ !== 1'b0) begin nFail++; $display("FAIL fifo_drained: got %b required 0", bus.oNEXT_REQ); end
    nChecks++; if (bus.oPREV_VALID !== 1'b0) begin nFail++; $display("FAIL read_no_ack: got %b required 0", bus.oPREV_VALID); end
  endtask

  task automatic test_store_ack();
    push_req(1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF);
    #1;
    nChecks++;
    if (bus.oNEXT_REQ !== 1'b1 || bus.oNEXT_RW !== 1'b1 || bus.oNEXT_ADDR !== 32'h200 || bus.oNEXT_DATA !== 32'hDEAD_BEEF) begin
      nFail++;
      $display("FAIL store_head: req=%b rw=%b addr=%h data=%h required 1/1/200/deadbeef",
               bus.oNEXT_REQ, bus.oNEXT_RW, bus.oNEXT_ADDR, bus.oNEXT_DATA);
    end
    tick();
    nChecks++; if (bus.oPREV_VALID !== 1'b0) begin nFail++; $display("FAIL store_ack_early: got %b required 0", bus.oPREV_VALID); end
    tick();
    nChecks++;
    if (bus.oPREV_VALID !== 1'b1 || bus.oPREV_STORE_ACK !== 1'b1 || bus.oPREV_DATA !== 64'h0) begin
      nFail++;
      $display("FAIL store_ack: valid=%b ack=%b data=%h required 1/1/0", bus.oPREV_VALID,
               bus.oPREV_STORE_ACK, bus.oPREV_DATA);
    end
    tick();
    nChecks++; if (bus.oPREV_VALID !== 1'b0) begin nFail++; $display("FAIL store_ack_once: got %b required 0", bus.oPREV_VALID); end
  endtask

  task automatic test_read_priority();
    push_req(1'b1, 1'b1, 32'h300, 32'h1234_5678);
    bus.iNEXT_VALID      = 1'b1;
    bus.iNEXT_DATA       = 64'h1122_3344_5566_7788;
    bus.iNEXT_MMU_FLAGS  = 28'hABC_DEF1;
    bus.iNEXT_PAGE_FAULT = 1'b1;
    tick();
    bus.iNEXT_VALID      = 1'b0;
    bus.iNEXT_PAGE_FAULT = 1'b0;
    #1;
    nChecks++;
    if (bus.oPREV_VALID !== 1'b1 || bus.oPREV_STORE_ACK !== 1'b0 || bus.oPREV_DATA !== 64'h1122_3344_5566_7788) begin
      nFail++;
      $display("FAIL read_first: valid=%b ack=%b data=%h required 1/0/1122334455667788",
               bus.oPREV_VALID, bus.oPREV_STORE_ACK, bus.oPREV_DATA);
    end
    nChecks++;
    if (bus.oPREV_PAGE_FAULT !== 1'b1 || bus.oPREV_MMU_FLAGS !== 28'hABC_DEF1 || bus.oPREV_QUEUE_FLUSH !== 1'b0) begin
      nFail++;
      $display("FAIL read_meta: pf=%b flags=%h qf=%b required 1/abcdef1/0", bus.oPREV_PAGE_FAULT,
               bus.oPREV_MMU_FLAGS, bus.oPREV_QUEUE_FLUSH);
    end
    tick();
    nChecks++;
    if (bus.oPREV_VALID !== 1'b1 || bus.oPREV_STORE_ACK !== 1'b1 || bus.oPREV_MMU_FLAGS !== 28'h0 || bus.oPREV_PAGE_FAULT !== 1'b0) begin
      nFail++;
      $display("FAIL ack_second: valid=%b ack=%b flags=%h pf=%b required 1/1/0/0", bus.oPREV_VALID,
               bus.oPREV_STORE_ACK, bus.oPREV_MMU_FLAGS, bus.oPREV_PAGE_FAULT);
    end
    tick();
    nChecks++; if (bus.oPREV_VALID !== 1'b0) begin nFail++; $display("FAIL ack_second_once: got %b required 0", bus.oPREV_VALID); end
  endtask

  task automatic test_busy_hold();
    bus.iNEXT_VALID = 1'b1;
    bus.iNEXT_DATA  = 64'hAAAA_0000_BBBB_1111;
    tick();
    bus.iPREV_BUSY  = 1'b1;
    bus.iNEXT_DATA  = 64'hCCCC_2222_DDDD_3333;
    #1;
    nChecks++; if (bus.oNEXT_BUSY !== 1'b1) begin nFail++; $display("FAIL busy_raise: got %b required 1", bus.oNEXT_BUSY); end
    for (int i = 0; i < 3; i++) begin
      tick();
      nChecks++;
      if (bus.oPREV_VALID !== 1'b1 || bus.oPREV_DATA !== 64'hAAAA_0000_BBBB_1111 || bus.oNEXT_BUSY !== 1'b1) begin
        nFail++;
        $display("FAIL busy_hold[%0d]: valid=%b data=%h busy=%b required 1/aaaa0000bbbb1111/1", i,
                 bus.oPREV_VALID, bus.oPREV_DATA, bus.oNEXT_BUSY);
      end
    end
    bus.iPREV_BUSY = 1'b0;
    #1;
    nChecks++; if (bus.oNEXT_BUSY !== 1'b0) begin nFail++; $display("FAIL busy_drop: got %b required 0", bus.oNEXT_BUSY); end
    tick();
    bus.iNEXT_VALID = 1'b0;
    nChecks++;
    if (bus.oPREV_VALID !== 1'b1 || bus.oPREV_DATA !== 64'hCCCC_2222_DDDD_3333) begin
      nFail++;
      $display("FAIL busy_next: valid=%b data=%h required 1/cccc2222dddd3333", bus.oPREV_VALID,
               bus.oPREV_DATA);
    end
    tick();
    nChecks++; if (bus.oPREV_VALID !== 1'b0) begin nFail++; $display("FAIL busy_idle: got %b required 0", bus.oPREV_VALID); end
  endtask

  task automatic test_ack_saturation();
    int acks;
    acks = 0;
    // Park a read return so every store ack has to wait in the counter.
    bus.iPREV_BUSY  = 1'b1;
    bus.iNEXT_VALID = 1'b1;
    bus.iNEXT_DATA  = 64'h5555_5555_5555_5555;
    tick();
    bus.iNEXT_VALID = 1'b0;
    for (int i = 0; i < 16; i++) push_req(1'b1, 1'b1, 32'h400 + 32'(4 * i), 32'(i));
    tick();
    tick();
    nChecks++; if (bus.oNEXT_REQ !== 1'b0) begin nFail++; $display("FAIL sat_req_drop: got %b required 0", bus.oNEXT_REQ); end
    nChecks++;
    if (bus.oNEXT_ADDR !== 32'h43C || bus.oNEXT_DATA !== 32'd15) begin
      nFail++;
      $display("FAIL sat_head: addr=%h data=%h required 43c/f", bus.oNEXT_ADDR, bus.oNEXT_DATA);
    end
    nChecks++;
    if (bus.oPREV_VALID !== 1'b1 || bus.oPREV_STORE_ACK !== 1'b0) begin
      nFail++;
      $display("FAIL sat_read_held: valid=%b ack=%b required 1/0", bus.oPREV_VALID, bus.oPREV_STORE_ACK);
    end
    bus.iPREV_BUSY = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.oPREV_VALID === 1'b1 && bus.oPREV_STORE_ACK === 1'b1) acks++;
    end
    nChecks++; if (acks != 16) begin nFail++; $display("FAIL sat_ack_count: got %0d required 16", acks); end
    nChecks++;
    if (bus.oNEXT_REQ !== 1'b0 || bus.oPREV_VALID !== 1'b0) begin
      nFail++;
      $display("FAIL sat_drained: req=%b valid=%b required 0/0", bus.oNEXT_REQ, bus.oPREV_VALID);
    end
  endtask

  task automatic test_async_reset();
    bus.iPREV_BUSY  = 1'b1;
    bus.iNEXT_VALID = 1'b1;
    bus.iNEXT_DATA  = 64'h9999_8888_7777_6666;
    tick();
    bus.iNEXT_VALID = 1'b0;
    push_req(1'b1, 1'b1, 32'h500, 32'h1);
    push_req(1'b1, 1'b1, 32'h504, 32'h2);
    tick();
    tick();
    bus.iNEXT_LOCK = 1'b1;
    for (int i = 0; i < 3; i++) push_req(1'b0, 1'b0, 32'h600 + 32'(4 * i), 32'h0);
    #3;
    nChecks++;
    if (bus.oNEXT_REQ !== 1'b1 || bus.oPREV_VALID !== 1'b1 || bus.oNEXT_ADDR !== 32'h600) begin
      nFail++;
      $display("FAIL arst_setup: req=%b valid=%b addr=%h required 1/1/600", bus.oNEXT_REQ,
               bus.oPREV_VALID, bus.oNEXT_ADDR);
    end
    inRESET = 1'b0;
    #1;
    nChecks++;
    if (bus.oPREV_VALID !== 1'b0 || bus.oPREV_DATA !== 64'h0 || bus.oNEXT_BUSY !== 1'b0) begin
      nFail++;
      $display("FAIL arst_prev: valid=%b data=%h busy=%b required 0/0/0", bus.oPREV_VALID,
               bus.oPREV_DATA, bus.oNEXT_BUSY);
    end
    nChecks++;
    if (bus.oNEXT_REQ !== 1'b0 || bus.oNEXT_ADDR !== 32'h0 || bus.oPREV_LOCK !== 1'b0) begin
      nFail++;
      $display("FAIL arst_next: req=%b addr=%h lock=%b required 0/0/0", bus.oNEXT_REQ,
               bus.oNEXT_ADDR, bus.oPREV_LOCK);
    end
    bus.iPREV_BUSY = 1'b0;
    bus.iNEXT_LOCK = 1'b0;
    #2;
    inRESET = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      nChecks++;
      if (bus.oPREV_VALID !== 1'b0 || bus.oNEXT_REQ !== 1'b0) begin
        nFail++;
        $display("FAIL arst_stale[%0d]: valid=%b req=%b required 0/0", i, bus.oPREV_VALID, bus.oNEXT_REQ);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fifo_order();
    test_store_ack();
    test_read_priority();
    test_busy_hold();
    test_ack_saturation();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", nChecks);
    $fatal(1, "watchdog");
  end

endmodule
